// File: rtl/tx_ram_sequencer_if.sv
`default_nettype none
// tx_ram_sequencer_if: instruction RAM read port (address out, 1-cycle-latency data back).
interface tx_ram_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] oInstrAddr;
  logic [127:0]      iInstr;

  modport master (output oInstrAddr, input iInstr);
  modport slave  (input oInstrAddr, output iInstr);
endinterface
`default_nettype wire

// File: rtl/tx_ram_sequencer.sv
`default_nettype none
// tx_ram_sequencer: RAM-driven transmit instruction sequencer (fire, outputs, ADC trigger, loops).
// Define TX_SEQ_WATCHDOG_EN to bound FIRE/ADC_TRIG execution to FIRE_TIMEOUT cycles.
module tx_ram_sequencer #(
  parameter int ADDR_W       = 12,
  parameter int FIRE_TIMEOUT = 65535
) (
  input  logic               txCLK,
  input  logic               rst,
  input  logic               iEnable,
  input  logic [ADDR_W-1:0]  iStartAddr,
  input  logic               iEmergency,
  tx_ram_sequencer_if.master imem,
  input  logic               iExtTrig,
  input  logic [7:0]         iFireComplete,
  input  logic               iAdcAck,
  output logic [ADDR_W-1:0]  oPhaseAddr,
  output logic               oFireArm,
  output logic [7:0]         oTrig,
  output logic [7:0]         oLed,
  output logic               oAdcTrig,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError
);

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_FIRE       = 8'h01;
  localparam logic [7:0] OP_SET_OUT    = 8'h02;
  localparam logic [7:0] OP_ADC_TRIG   = 8'h03;
  localparam logic [7:0] OP_LOOP_START = 8'h04;
  localparam logic [7:0] OP_LOOP_END   = 8'h05;
  localparam logic [7:0] OP_WAIT_TRIG  = 8'h06;
  localparam logic [7:0] OP_HALT       = 8'h07;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DELAY, S_HALTED, S_ERROR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   next_pc;
  logic [31:0]       delay_cnt;
  logic [7:0]        exec_op;
  logic [29:0]       loop_cnt [8];
  logic [ADDR_W-1:0] loop_ret [8];

  logic [7:0]        opcode;
  logic [2:0]        loop_k;
  logic [ADDR_W-1:0] operand;
  logic [31:0]       delay_d;
  logic [ADDR_W:0]   pc_inc;
  logic [ADDR_W:0]   loop_target;
  logic              exec_done;
  logic              bad_opcode;
  logic              pc_overflow;
  logic              wd_expire;
  logic              fault;
  logic              unused_bits;

  assign opcode      = imem.iInstr[127:120];
  assign loop_k      = imem.iInstr[98:96];
  assign operand     = ADDR_W'(imem.iInstr[107:96]);
  assign delay_d     = imem.iInstr[63:32];
  assign pc_inc      = {1'b0, pc} + (ADDR_W+1)'(1);
  assign loop_target = {1'b0, loop_ret[loop_k]} + (ADDR_W+1)'(1);
  assign unused_bits = ^{imem.iInstr[119:108], imem.iInstr[95:94], imem.iInstr[31:0]};

  assign exec_done = (exec_op == OP_FIRE      && iFireComplete == 8'hFF) ||
                     (exec_op == OP_ADC_TRIG  && iAdcAck) ||
                     (exec_op == OP_WAIT_TRIG && iExtTrig);

  assign bad_opcode  = (state == S_DECODE) && (opcode > OP_HALT);
  // The PC never wraps: stepping past the top of the instruction RAM is a fault.
  assign pc_overflow = (state == S_DELAY) && (delay_cnt == 32'd0) && next_pc[ADDR_W];

`ifdef TX_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(FIRE_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(FIRE_TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == S_EXEC) && (exec_op != OP_WAIT_TRIG) && !exec_done &&
                     (wd_cnt == WD_LAST);

  always_ff @(posedge txCLK) begin
    if (rst || state == S_DECODE) begin
      wd_cnt <= '0;
    end else if (state == S_EXEC) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  assign fault = bad_opcode || pc_overflow || wd_expire;

  always_ff @(posedge txCLK) begin
    if (rst) begin
      state           <= S_IDLE;
      pc              <= '0;
      next_pc         <= '0;
      delay_cnt       <= '0;
      exec_op         <= OP_NOP;
      imem.oInstrAddr <= '0;
      oPhaseAddr      <= '0;
      oFireArm        <= 1'b0;
      oTrig           <= '0;
      oLed            <= '0;
      oAdcTrig        <= 1'b0;
      oBusy           <= 1'b0;
      oDone           <= 1'b0;
      oError          <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        loop_cnt[i] <= '0;
        loop_ret[i] <= '0;
      end
    end else if (iEmergency || (iEnable && fault)) begin
      state    <= S_ERROR;
      oFireArm <= 1'b0;
      oAdcTrig <= 1'b0;
      oTrig    <= '0;
      oLed     <= '0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oError   <= 1'b1;
    end else if (!iEnable && state != S_ERROR) begin
      state    <= S_IDLE;
      oFireArm <= 1'b0;
      oAdcTrig <= 1'b0;
      oTrig    <= '0;
      oLed     <= '0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          pc              <= iStartAddr;
          imem.oInstrAddr <= iStartAddr;
          oBusy           <= 1'b1;
          state           <= S_FETCH;
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          delay_cnt <= delay_d;
          exec_op   <= opcode;
          next_pc   <= pc_inc;
          state     <= S_DELAY;
          case (opcode)
            OP_FIRE: begin
              oPhaseAddr <= operand;
              oFireArm   <= 1'b1;
              state      <= S_EXEC;
            end
            OP_SET_OUT: begin
              oTrig <= imem.iInstr[79:72];
              oLed  <= imem.iInstr[71:64];
            end
            OP_ADC_TRIG: begin
              oAdcTrig <= 1'b1;
              state    <= S_EXEC;
            end
            OP_LOOP_START: begin
              loop_cnt[loop_k] <= imem.iInstr[93:64];
              loop_ret[loop_k] <= pc;
            end
            OP_LOOP_END: begin
              if (loop_cnt[loop_k] > 30'd1) begin
                loop_cnt[loop_k] <= loop_cnt[loop_k] - 30'd1;
                next_pc          <= loop_target;
              end else begin
                loop_cnt[loop_k] <= '0;
              end
            end
            OP_WAIT_TRIG: state <= S_EXEC;
            OP_HALT: begin
              oDone <= 1'b1;
              oBusy <= 1'b0;
              state <= S_HALTED;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          if (exec_done) begin
            oFireArm <= 1'b0;
            oAdcTrig <= 1'b0;
            state    <= S_DELAY;
          end
        end
        S_DELAY: begin
          if (delay_cnt != 32'd0) begin
            delay_cnt <= delay_cnt - 32'd1;
          end else begin
            pc              <= next_pc[ADDR_W-1:0];
            imem.oInstrAddr <= next_pc[ADDR_W-1:0];
            state           <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
